// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data memory responder and its stall logic.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W              = 32;
  localparam int WORD_BYTES          = 4;
  // The MEM-stage stall logic assumes this latency unless told otherwise.
  localparam int DEFAULT_WAIT_STATES = 2;

endpackage

// File: rtl/data_mem_ram.sv
// Single-port word RAM: synchronous write, combinational read of the addressed word.
module data_mem_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder with configurable wait states and a one-cycle rdy pulse.
// Optional build macro MEM_ALIGN_CHECK_EN adds the misalign output and suppresses unaligned accesses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] data_out,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic        rdy
);

  localparam int OFS_W   = $clog2(WORD_BYTES);
  localparam int CNT_W   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int WS_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              req, accept;
  logic [ADDR_W-1:0] req_idx, lat_idx, acc_idx;
  logic [DATA_W-1:0] lat_data, acc_wdata, ram_rdata;
  logic              req_mis, lat_mis, acc_mis;
  logic              lat_wr, acc_wr, acc_en, ram_we;
  logic              unused_addr_bits;

  assign req     = memRead | memWrite;
  assign accept  = (state == IDLE) && req;
  assign req_idx = addr[ADDR_W+OFS_W-1:OFS_W];
`ifdef MEM_ALIGN_CHECK_EN
  assign req_mis = (addr[OFS_W-1:0] != '0);
`else
  assign req_mis = 1'b0;
`endif
  // Upper bits alias modulo depth; byte offset only matters for the alignment check.
  assign unused_addr_bits = ^{addr[31:ADDR_W+OFS_W], addr[OFS_W-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so it uses the live request.
  always_comb begin
    rdy       = (state == RESP);
    acc_en    = 1'b0;
    acc_idx   = lat_idx;
    acc_wdata = lat_data;
    acc_wr    = lat_wr;
    acc_mis   = lat_mis;
    case (state)
      IDLE: begin
        if (WAIT_STATES == 0 && req) begin
          acc_en    = 1'b1;
          acc_idx   = req_idx;
          acc_wdata = data_in;
          acc_wr    = memWrite;
          acc_mis   = req_mis;
        end
      end
      WAIT:    acc_en = (cnt == '0);
      default: ;
    endcase
    // A reset landing on the access edge abandons the write.
    ram_we = acc_en && acc_wr && !acc_mis && rst_n;
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (state == RESP) && lat_mis;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      data_out <= '0;
    end else begin
      if (accept)                         cnt <= CNT_W'(WS_LOAD);
      else if (state == WAIT && cnt != '0) cnt <= cnt - CNT_W'(1);
      if (acc_en && !acc_wr) data_out <= acc_mis ? '0 : ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_idx  <= req_idx;
      lat_data <= data_in;
      lat_wr   <= memWrite;
      lat_mis  <= req_mis;
    end
  end

  data_mem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a 2-wait-state instance and a 0-wait-state instance.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int ADDR_W = 10;
  localparam int WS     = 2;

  typedef struct {
    logic [31:0] dout;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0, data_in = '0, data_out;
  logic        memRead = 1'b0, memWrite = 1'b0, rdy;
  logic [31:0] addr0 = '0, data_in0 = '0, data_out0;
  logic        memRead0 = 1'b0, memWrite0 = 1'b0, rdy0;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign, misalign0;
`endif

  int checks = 0;
  int passed = 0;
  exp_t q[$];
  exp_t q0[$];
  logic [31:0] model_mem [int];
  logic [31:0] model_dout = '0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in),
    .memRead(memRead), .memWrite(memWrite), .data_out(data_out),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign(misalign),
`endif
    .rdy(rdy)
  );

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr0), .data_in(data_in0),
    .memRead(memRead0), .memWrite(memWrite0), .data_out(data_out0),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign(misalign0),
`endif
    .rdy(rdy0)
  );

  // Response monitors: every rdy pulse pops one expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rdy) begin
      checks++;
      if (q.size() == 0) begin
        $display("FAIL rdy_unexpected: rdy=1 with nothing outstanding, data_out=%h", data_out);
      end else begin
        e = q.pop_front();
        if (data_out !== e.dout)
          $display("FAIL resp_data: data_out=%h expected %h", data_out, e.dout);
        else passed++;
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (misalign !== e.mis)
          $display("FAIL resp_misalign: misalign=%b expected %b", misalign, e.mis);
        else passed++;
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rdy0) begin
      checks++;
      if (q0.size() == 0) begin
        $display("FAIL rdy0_unexpected: rdy=1 with nothing outstanding, data_out=%h", data_out0);
      end else begin
        e = q0.pop_front();
        if (data_out0 !== e.dout)
          $display("FAIL resp0_data: data_out=%h expected %h", data_out0, e.dout);
        else passed++;
      end
    end
  end

  // One request on the WS=2 instance; optionally scrambles the inputs while in WAIT.
  task automatic txn(input bit wr, input bit rd, input logic [31:0] a,
                     input logic [31:0] d, input bit scramble);
    int  idx;
    bit  mis;
    bit  got;
    exp_t e;
    idx = int'((a >> 2) & 32'((1 << ADDR_W) - 1));
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`endif
    if (wr) begin
      if (!mis) model_mem[idx] = d;
    end else begin
      model_dout = mis ? 32'h0 : model_mem[idx];
    end
    e.dout = model_dout;
    e.mis  = mis;
    q.push_back(e);
    memWrite = wr; memRead = rd; addr = a; data_in = d;
    got = 1'b0;
    for (int k = 1; k <= WS + 8 && !got; k++) begin
      @(negedge clk);
      if (scramble && k == 1) begin
        addr = ~a; data_in = ~d; memWrite = ~wr;
      end
      if (rdy) begin
        got = 1'b1;
        checks++;
        if (k != WS + 1) $display("FAIL latency: rdy after %0d edges expected %0d", k, WS + 1);
        else passed++;
        memWrite = 1'b0; memRead = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      $display("FAIL rdy_timeout: rdy=0 after %0d edges expected 1", WS + 8);
      memWrite = 1'b0; memRead = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0 || data_out !== model_dout)
      $display("FAIL hold_after_rdy: rdy=%b data_out=%h expected rdy=0 data_out=%h",
               rdy, data_out, model_dout);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      checks++;
      if ({rdy, rdy0} !== 2'b00 || data_out !== 32'h0 || data_out0 !== 32'h0)
        $display("FAIL reset_idle: rdy=%b rdy0=%b data_out=%h data_out0=%h expected all 0",
                 rdy, rdy0, data_out, data_out0);
      else passed++;
    end
  endtask

  task automatic test_write_read();
    txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    txn(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (data_out !== 32'hDEADBEEF)
      $display("FAIL dout_held_idle: data_out=%h expected deadbeef", data_out);
    else passed++;
  endtask

  task automatic test_priority_alias();
    txn(1'b1, 1'b1, 32'h4, 32'h1234, 1'b0);
    txn(1'b0, 1'b1, 32'h4 + (32'd4 << ADDR_W), 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    txn(1'b1, 1'b0, 32'h3FC, 32'h0BADC0DE, 1'b0);
    txn(1'b0, 1'b1, 32'h3FC, 32'h0, 1'b1);
    txn(1'b0, 1'b1, 32'h10, 32'h0, 1'b1);
  endtask

  task automatic test_ws0();
    exp_t e;
    e.mis = 1'b0;
    e.dout = 32'h0;
    q0.push_back(e);
    memWrite0 = 1'b1; addr0 = 32'h8; data_in0 = 32'hA5A5A5A5;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) $display("FAIL ws0_write_latency: rdy=%b expected 1", rdy0);
    else passed++;
    memWrite0 = 1'b0;
    @(negedge clk);
    e.dout = 32'hA5A5A5A5;
    repeat (3) q0.push_back(e);
    memRead0 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (rdy0 !== 1'(k % 2))
        $display("FAIL ws0_throughput: cycle %0d rdy=%b expected %b", k, rdy0, 1'(k % 2));
      else passed++;
    end
    memRead0 = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b0 || data_out0 !== 32'hA5A5A5A5)
      $display("FAIL ws0_idle: rdy=%b data_out=%h expected 0 a5a5a5a5", rdy0, data_out0);
    else passed++;
  endtask

  task automatic test_reset_midop();
    txn(1'b1, 1'b0, 32'h20, 32'h600DF00D, 1'b0);
    memWrite = 1'b1; addr = 32'h20; data_in = 32'hCAFEF00D;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (rdy !== 1'b0 || (k >= 3 && data_out !== 32'h0))
        $display("FAIL reset_midop: cycle %0d rdy=%b data_out=%h expected rdy=0", k, rdy, data_out);
      else passed++;
      if (k == 2) begin rst_n = 1'b0; memWrite = 1'b0; end
      if (k == 3) rst_n = 1'b1;
    end
    model_dout = 32'h0;
    txn(1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    txn(1'b1, 1'b0, 32'h22, 32'hBADBAD00, 1'b0);
    txn(1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
    txn(1'b0, 1'b1, 32'h22, 32'h0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_priority_alias();
    test_back_to_back();
    test_ws0();
    test_reset_midop();
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign();
`endif
    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0 || q0.size() != 0)
      $display("FAIL scoreboard_drain: %0d/%0d responses outstanding expected 0", q.size(), q0.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
